// File: rtl/sid_i2s_tx.sv
// SID audio to I2S serializer: one-entry holding buffer feeding a
// 64-bit I2S frame that carries the same sample on both channels.
module sid_i2s_tx #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        mute,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        underrun
);

  localparam logic [7:0] DIV_MAX = 8'(BCLK_DIV - 1);

  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_nxt;
  logic [5:0]  idx_l;
  logic [5:0]  idx_r;
  logic [15:0] hold;
  logic [15:0] frame_word;
  logic        hold_empty;
  logic        tick;
  logic        fall;
  logic        load;
  logic        accept;
  logic        sbit;

  assign sample_ready = hold_empty;
  assign tick    = (div_cnt == DIV_MAX);
  assign fall    = tick & i2s_bclk;
  assign load    = fall & (bit_cnt == 6'd63);
  assign accept  = sample_valid & hold_empty;
  assign bit_nxt = bit_cnt + 6'd1;
  assign idx_l   = 6'd16 - bit_nxt;
  assign idx_r   = 6'd48 - bit_nxt;

  // Serial bit for the slot the bit counter is about to enter
  always_comb begin
    sbit = 1'b0;
    unique case (1'b1)
      (bit_nxt >= 6'd1 && bit_nxt <= 6'd16):
        sbit = frame_word[idx_l[3:0]];
      (bit_nxt >= 6'd33 && bit_nxt <= 6'd48):
        sbit = frame_word[idx_r[3:0]];
      default:
        sbit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (tick) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else if (fall) begin
      bit_cnt   <= bit_nxt;
      i2s_lrclk <= bit_nxt[5];
      i2s_sdata <= sbit;
    end
  end

  // A load empties the buffer, but a same-edge write refills it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold        <= '0;
      hold_empty  <= 1'b1;
      frame_word  <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= load;
      underrun    <= load & hold_empty;
      if (accept)
        hold <= sample_in;
      if (load) begin
        hold_empty <= ~accept;
        if (mute)
          frame_word <= '0;
        else if (!hold_empty)
          frame_word <= hold;
      end else if (accept) begin
        hold_empty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Bench for sid_i2s_tx: frame-level vector table, random traffic
// against a time-based model, reset and divider sweep checks.
module tb_sid_i2s_tx;

  localparam int DIV = 2;
  localparam int FR  = 128 * DIV;
  localparam int NT  = 11;
  localparam int NR  = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b0;
  logic        sample_ready;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata;
  logic        frame_start, underrun;

  logic        r1, b1, l1, s1, f1, u1;
  logic        r3, b3, l3, s3, f3, u3;

  always #5 clk = ~clk;

  sid_i2s_tx #(.BCLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .mute(mute),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .frame_start(frame_start),
    .underrun(underrun)
  );

  sid_i2s_tx #(.BCLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset),
    .sample_in(16'h0), .sample_valid(1'b0),
    .sample_ready(r1), .mute(1'b0),
    .i2s_bclk(b1), .i2s_lrclk(l1),
    .i2s_sdata(s1), .frame_start(f1),
    .underrun(u1)
  );

  sid_i2s_tx #(.BCLK_DIV(3)) dut3 (
    .clk(clk), .reset(reset),
    .sample_in(16'h0), .sample_valid(1'b0),
    .sample_ready(r3), .mute(1'b0),
    .i2s_bclk(b3), .i2s_lrclk(l3),
    .i2s_sdata(s3), .frame_start(f3),
    .underrun(u3)
  );

  typedef struct {
    int          off;
    logic [15:0] data;
    logic        dup;
    logic        mute;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [NT];

  int total = 0;
  int bad = 0;
  int t;
  logic [15:0] m_hold, m_word;
  logic        m_empty, m_fs, m_ur;
  logic [15:0] cap_l, cap_r;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
    end
  endtask

  function automatic logic exp_sd(int n, logic [15:0] w);
    if (n >= 1 && n <= 16) return w[16-n];
    if (n >= 33 && n <= 48) return w[48-n];
    return 1'b0;
  endfunction

  task automatic model_reset();
    t = 0;
    m_word = '0;
    m_hold = '0;
    m_empty = 1'b1;
    m_fs = 1'b0;
    m_ur = 1'b0;
  endtask

  // One clk edge: drive, advance model, compare at the falling edge
  task automatic cyc(input logic v, input logic [15:0] d,
                     input logic m);
    logic acc;
    int   n;
    sample_valid = v;
    sample_in = d;
    mute = m;
    @(posedge clk);
    t++;
    acc = v && m_empty;
    m_fs = 1'b0;
    m_ur = 1'b0;
    if (t % FR == 0) begin
      m_fs = 1'b1;
      m_ur = m_empty;
      if (m) m_word = '0;
      else if (!m_empty) m_word = m_hold;
      m_empty = !acc;
    end else if (acc) begin
      m_empty = 1'b0;
    end
    if (acc) m_hold = d;
    @(negedge clk);
    n = (t / (2 * DIV)) % 64;
    chk("bclk", i2s_bclk, ((t / DIV) % 2));
    chk("lrclk", i2s_lrclk, (n >= 32));
    chk("sdata", i2s_sdata, exp_sd(n, m_word));
    chk("ready", sample_ready, m_empty);
    chk("frame_start", frame_start, m_fs);
    chk("underrun", underrun, m_ur);
    if (n >= 1 && n <= 16) cap_l[16-n] = i2s_sdata;
    if (n >= 33 && n <= 48) cap_r[48-n] = i2s_sdata;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_bclk"}, i2s_bclk, 0);
    chk({tag, "_lrclk"}, i2s_lrclk, 0);
    chk({tag, "_sdata"}, i2s_sdata, 0);
    chk({tag, "_ready"}, sample_ready, 1);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_ur"}, underrun, 0);
  endtask

  initial begin
    logic        v, m;
    logic [15:0] d;
    int          last_b [2];
    int          last_l [2];
    int          last_f [2];
    int          divs [2];
    logic        pb [2];
    logic        pl [2];
    logic        bc, lc, fc;

    vt[0]  = '{5,   16'hA5C3, 1'b0, 1'b0, 16'h0000};
    vt[1]  = '{-1,  16'h0000, 1'b0, 1'b0, 16'hA5C3};
    vt[2]  = '{-1,  16'h0000, 1'b0, 1'b0, 16'hA5C3};
    vt[3]  = '{0,   16'h1234, 1'b0, 1'b0, 16'hA5C3};
    vt[4]  = '{-1,  16'h0000, 1'b0, 1'b0, 16'h1234};
    vt[5]  = '{100, 16'h8000, 1'b0, 1'b0, 16'h1234};
    vt[6]  = '{-1,  16'h0000, 1'b0, 1'b1, 16'h0000};
    vt[7]  = '{-1,  16'h0000, 1'b0, 1'b0, 16'h0000};
    vt[8]  = '{10,  16'h7FFF, 1'b1, 1'b0, 16'h0000};
    vt[9]  = '{-1,  16'h0000, 1'b0, 1'b0, 16'h7FFF};
    vt[10] = '{-1,  16'h0000, 1'b0, 1'b1, 16'h0000};

    t = 0;
    cap_l = '0;
    cap_r = '0;
    #12;
    chk_reset_vals("rst0");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    for (int f = 0; f < NT + NR; f++) begin
      for (int off = 0; off < FR; off++) begin
        if (f == 0 && off == 0) continue;
        if (f < NT) begin
          v = (off == vt[f].off) ||
              (vt[f].dup && off == vt[f].off + 1);
          d = (off == vt[f].off) ? vt[f].data : ~vt[f].data;
          m = (off == 0) ? vt[f].mute : 1'b0;
        end else begin
          v = ($urandom_range(0, 63) == 0);
          d = 16'($urandom);
          m = 1'($urandom_range(0, 1));
        end
        cyc(v, d, m);
      end
      if (f < NT) begin
        chk("vec_left", cap_l, vt[f].exp);
        chk("vec_right", cap_r, vt[f].exp);
      end else begin
        chk("rnd_left", cap_l, m_word);
        chk("rnd_right", cap_r, m_word);
      end
    end

    for (int off = 0; off <= 82; off++)
      cyc(off == 5, 16'hBEEF, 1'b0);
    chk("pre_rst_ready", sample_ready, 0);
    chk("pre_rst_bclk", i2s_bclk, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_hold");
    reset = 1'b0;
    model_reset();
    for (int k = 1; k < FR + 20; k++) begin
      cyc(1'b0, 16'h0, 1'($urandom_range(0, 1)));
      if (k == FR - 1) begin
        chk("post_rst_left", cap_l, 0);
        chk("post_rst_right", cap_r, 0);
      end
    end

    reset = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    t = 0;
    divs[0] = 1;
    divs[1] = 3;
    for (int i = 0; i < 2; i++) begin
      last_b[i] = -1;
      last_l[i] = -1;
      last_f[i] = -1;
      pb[i] = 1'b0;
      pl[i] = 1'b0;
    end
    for (int k = 0; k < 3 * 128 * 3 + 8; k++) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bc = (i == 0) ? b1 : b3;
        lc = (i == 0) ? l1 : l3;
        fc = (i == 0) ? f1 : f3;
        if (bc && !pb[i]) begin
          if (last_b[i] < 0) chk("first_bclk", t, divs[i]);
          else chk("bclk_period", t - last_b[i], 2 * divs[i]);
          last_b[i] = t;
        end
        if (lc && !pl[i]) begin
          if (last_l[i] < 0) chk("first_lr", t, 64 * divs[i]);
          else chk("lr_period", t - last_l[i], 128 * divs[i]);
          last_l[i] = t;
        end
        if (fc) begin
          if (last_f[i] < 0) chk("first_fs", t, 128 * divs[i]);
          else chk("fs_spacing", t - last_f[i], 128 * divs[i]);
          last_f[i] = t;
        end
        pb[i] = bc;
        pl[i] = lc;
      end
    end
    chk("sweep_fs_seen1", (last_f[0] > 0), 1);
    chk("sweep_fs_seen3", (last_f[1] > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sid_i2s_tx.md
SID_I2S_TX -- requirements
Module: sid_i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 4, meaning clk cycles per half bit-clock period; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sample_in  input  16  two's-complement mono sample, i.e. the SID filter/mixer audio output.
REQ-005 SHALL have port sample_valid  input  1  sample_in is offered this cycle.
REQ-006 SHALL have port sample_ready  output  1  holding buffer empty; sample accepted when valid and ready are both high.
REQ-007 SHALL have port mute  input  1  force the next loaded frame word to zero.
REQ-008 SHALL have port i2s_bclk  output  1  serial bit clock.
REQ-009 SHALL have port i2s_lrclk  output  1  word select: 0 = left, 1 = right.
REQ-010 SHALL have port i2s_sdata  output  1  serial data, MSB first.
REQ-011 SHALL have port frame_start  output  1  one-clk pulse on the cycle a frame word is loaded.
REQ-012 SHALL have port underrun  output  1  one-clk pulse when a frame load finds the holding buffer empty.

Function
REQ-013 SHALL accept one sample into a one-entry holding buffer; sample_ready = NOT holding_full, driven directly from a register.
REQ-014 SHALL keep a divider counter 0..BCLK_DIV-1 and toggle i2s_bclk on each cycle the counter equals BCLK_DIV-1, then wrap the counter to 0.
REQ-015 SHALL keep a 6-bit bit counter that increments, wrapping 63->0, on each clk edge where i2s_bclk goes 1->0; one frame is 64 bclk = 128*BCLK_DIV clk.
REQ-016 SHALL load the frame word on the clk edge where the bit counter wraps 63->0; frame_start pulses on that same edge.
REQ-017 On load with the holding buffer full, the frame word SHALL take the holding value (or 0 if mute=1), and the holding buffer SHALL empty.
REQ-018 On load with the holding buffer empty, the frame word SHALL keep its previous value (or become 0 if mute=1), and underrun SHALL pulse.
REQ-019 If valid&ready occur on the load edge, the sample SHALL enter the holding buffer, not the frame word; latency is always at least one frame boundary.
REQ-020 While holding is full, sample_valid SHALL be ignored and sample_in SHALL not be captured.
REQ-021 i2s_lrclk SHALL be 0 for bit counter 0..31 and 1 for 32..63.
REQ-022 i2s_sdata SHALL be frame_word[16-n] for bit counter n = 1..16, frame_word[48-n] for n = 33..48, and 0 otherwise; this is I2S one-bit delay with the same sample on both channels.
REQ-023 i2s_bclk, i2s_lrclk and i2s_sdata SHALL be registered and change on the same clk edge as the bit counter.
REQ-024 mute SHALL be sampled only at the load edge; mute changes mid-frame SHALL not alter the current frame.

Reset
REQ-025 Asserting reset SHALL immediately force: divider=0, bit counter=0, i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, frame word=0, holding empty (sample_ready=1), frame_start=0, underrun=0.
REQ-026 Reset asserted mid-frame SHALL discard the holding buffer and frame word; the first frame after reset outputs zeros.
REQ-027 After reset release, the first i2s_bclk rising edge SHALL occur BCLK_DIV clk edges later.

Verification
REQ-028 With BCLK_DIV=2: after reset, write 0xA5C3 at cycle 5 -> sample_ready low from cycle 6; the first frame (256 clk) outputs all-zero sdata; the second frame outputs 1010010111000011 on left bits 1..16 and right bits 33..48.
REQ-029 Run with no writes after one sample -> at each later frame load, underrun pulses for 1 clk and the previous word (0xA5C3) repeats.
REQ-030 Drive sample_valid on exactly the 63->0 load edge with holding empty -> frame_start=1 and underrun=1 on that edge; the sample appears one frame later.
REQ-031 Write 0x8000 with mute=1 held only at the load edge -> that frame is all-zero sdata; the holding buffer is consumed (sample_ready=1 afterwards).
REQ-032 Assert reset at bit counter 20 with holding full -> all outputs go to their reset values asynchronously, sample_ready=1, and the next frame is silent.
REQ-033 Sweep BCLK_DIV in {1,3} -> i2s_bclk period is 2*BCLK_DIV clk, i2s_lrclk period is 128*BCLK_DIV clk, and frame_start spacing equals the i2s_lrclk period.
